// File: rtl/stage0_cfg_loader_pkg.sv
// stage0_cfg_pkg
// Shared types and constants for the stage0 configuration loader.
// Holds the word width that matches stage0, the lane/tap/BN geometry,
// and the loader state encoding.
package stage0_cfg_pkg;

  localparam int INT_BITS    = 13;
  localparam int CH          = 9;
  localparam int TAPS        = 9;
  localparam int BN_WORDS    = 2;
  localparam int TOTAL_WORDS = CH * TAPS + CH * BN_WORDS;

  typedef enum logic [2:0] {
    IDLE,
    W_COLLECT,
    W_PUSH,
    BN_COLLECT,
    BN_PUSH,
    DONE
  } cfg_state_e;

endpackage

// File: rtl/stage0_cfg_loader_if.sv
// stage0_cfg_loader_if
// Host-side config word stream (valid/ready).
//   s_data  : config word, INT_BITS wide
//   s_valid : host has a word on s_data
//   s_ready : loader accepts a word; transfer on s_valid & s_ready
// master = host, slave = loader.
interface stage0_cfg_loader_if;
  import stage0_cfg_pkg::*;

  logic [INT_BITS-1:0] s_data;
  logic                s_valid;
  logic                s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);

endinterface

// File: rtl/stage0_cfg_loader.sv
// stage0_cfg_loader
// Packs a 99-word host stream into nine weight lanes and BN scale/bias
// pairs, and strobes them into stage0: nine tap loads (mode 0) followed
// by nine BN shifts (mode 1).
// Ports:
//   clk         : clock, rising edge
//   reset       : asynchronous, active-low
//   start       : begin a load sequence (only seen in IDLE)
//   host        : config word stream (slave side)
//   cfg_lane    : weight lanes to stage0 in[8:0]
//   cfg_bn      : [0]=scale, [1]=bias to stage0 BN_config_in
//   weight_en   : one-cycle load strobe
//   weight_mode : 0 = tap load, 1 = BN shift
//   busy        : sequence in progress
//   done        : one-cycle pulse at end of sequence
module stage0_cfg_loader
  import stage0_cfg_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  stage0_cfg_loader_if.slave               host,
  output logic [CH-1:0][INT_BITS-1:0]      cfg_lane,
  output logic [1:0][INT_BITS-1:0]         cfg_bn,
  output logic                             weight_en,
  output logic                             weight_mode,
  output logic                             busy,
  output logic                             done
);

  localparam logic [3:0] LAST_LANE = 4'(CH - 1);
  localparam logic [3:0] LAST_TAP  = 4'(TAPS - 1);
  localparam logic [3:0] LAST_CH   = 4'(CH - 1);
  localparam logic [3:0] LAST_BN   = 4'(BN_WORDS - 1);

  cfg_state_e state, state_next;
  logic [3:0] lane_cnt;
  logic [3:0] tap_cnt;
  logic [3:0] ch_cnt;
  logic       xfer;

  assign host.s_ready = (state == W_COLLECT) || (state == BN_COLLECT);
  assign xfer         = host.s_valid && host.s_ready;
  assign busy         = (state != IDLE);

  // Next-state decode. lane_cnt doubles as the word index inside a BN
  // pair, since it is already cleared when each collect phase begins.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:       if (start) state_next = W_COLLECT;
      W_COLLECT:  if (xfer && lane_cnt == LAST_LANE) state_next = W_PUSH;
      W_PUSH:     state_next = (tap_cnt == LAST_TAP) ? BN_COLLECT : W_COLLECT;
      BN_COLLECT: if (xfer && lane_cnt == LAST_BN) state_next = BN_PUSH;
      BN_PUSH:    state_next = (ch_cnt == LAST_CH) ? DONE : BN_COLLECT;
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // State, counters and output registers. The strobes are decoded from
  // state_next so they are high in exactly the push/done state's cycle
  // while still coming straight from flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      lane_cnt    <= '0;
      tap_cnt     <= '0;
      ch_cnt      <= '0;
      cfg_lane    <= '0;
      cfg_bn      <= '0;
      weight_en   <= 1'b0;
      weight_mode <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_next;
      weight_en   <= (state_next == W_PUSH) || (state_next == BN_PUSH);
      weight_mode <= (state_next == BN_PUSH);
      done        <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            lane_cnt <= '0;
            tap_cnt  <= '0;
            ch_cnt   <= '0;
          end
        end
        W_COLLECT: begin
          if (xfer) begin
            cfg_lane[lane_cnt] <= host.s_data;
            lane_cnt           <= lane_cnt + 4'd1;
          end
        end
        W_PUSH: begin
          lane_cnt <= '0;
          tap_cnt  <= tap_cnt + 4'd1;
        end
        BN_COLLECT: begin
          if (xfer) begin
            cfg_bn[lane_cnt[0]] <= host.s_data;
            lane_cnt            <= lane_cnt + 4'd1;
          end
        end
        BN_PUSH: begin
          lane_cnt <= '0;
          ch_cnt   <= ch_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stage0_cfg_loader.sv
// tb_stage0_cfg_loader
// Directed bench for stage0_cfg_loader: reset/idle, full load without
// stalls, load with one stall per word, start pulses during a load, and
// reset in the middle of the BN phase followed by a clean reload.
module tb_stage0_cfg_loader;
  import stage0_cfg_pkg::*;

  logic clk;
  logic reset;
  logic start;
  logic [CH-1:0][INT_BITS-1:0] cfg_lane;
  logic [1:0][INT_BITS-1:0]    cfg_bn;
  logic weight_en;
  logic weight_mode;
  logic busy;
  logic done;

  int assertions;
  int failures;
  bit host_timeout;

  stage0_cfg_loader_if host_if ();

  stage0_cfg_loader dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .host        (host_if),
    .cfg_lane    (cfg_lane),
    .cfg_bn      (cfg_bn),
    .weight_en   (weight_en),
    .weight_mode (weight_mode),
    .busy        (busy),
    .done        (done)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it, and on mismatch counts and reports it.
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    assertions++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Wait at falling edges until the loader is ready, with a cycle bound.
  task automatic wait_ready();
    int g;
    g = 0;
    while (!host_if.s_ready && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) host_timeout = 1'b1;
  endtask

  // Host side: sends words 1..n_words. With stall set, each word is
  // preceded by exactly one collect cycle with s_valid low.
  task automatic apply_stimulus(input bit stall, input int n_words);
    for (int i = 1; i <= n_words; i++) begin
      if (stall) begin
        wait_ready();
        host_if.s_valid = 1'b0;
        @(negedge clk);
      end
      host_if.s_valid = 1'b1;
      host_if.s_data  = INT_BITS'(i);
      wait_ready();
      @(negedge clk);
    end
    host_if.s_valid = 1'b0;
    host_if.s_data  = '0;
  endtask

  // Watches the strobes after edge 0 and checks every push's contents,
  // timing (when not stalling), and the done edge.
  task automatic run_monitor(input bit stall, input int exp_done_edge);
    int push_idx;
    int done_edge;
    int done_count;
    bit prev_en;
    int j;
    push_idx   = 0;
    done_edge  = -1;
    done_count = 0;
    prev_en    = 1'b0;
    for (int n = 1; n <= 400 && done_edge < 0; n++) begin
      @(negedge clk);
      if (weight_en) begin
        check_output($sformatf("en_back_to_back_e%0d", n), prev_en, 1'b0);
        check_output($sformatf("s_ready_in_push_e%0d", n), host_if.s_ready, 1'b0);
        if (push_idx < TAPS) begin
          check_output($sformatf("mode_tap%0d", push_idx), weight_mode, 1'b0);
          for (int l = 0; l < CH; l++)
            check_output($sformatf("lane_t%0d_l%0d", push_idx, l), cfg_lane[l],
                         9 * push_idx + l + 1);
          if (!stall)
            check_output($sformatf("tap_push_edge%0d", push_idx), n, 9 + 10 * push_idx);
        end else begin
          j = push_idx - TAPS;
          check_output($sformatf("mode_bn%0d", j), weight_mode, 1'b1);
          check_output($sformatf("bn_scale%0d", j), cfg_bn[0], 82 + 2 * j);
          check_output($sformatf("bn_bias%0d", j), cfg_bn[1], 83 + 2 * j);
          if (!stall)
            check_output($sformatf("bn_push_edge%0d", j), n, 92 + 3 * j);
        end
        push_idx++;
      end
      prev_en = weight_en;
      if (done) begin
        done_edge = n;
        done_count++;
        check_output("busy_during_done", busy, 1'b1);
      end
    end
    check_output("push_count", push_idx, 18);
    check_output("done_edge", done_edge, exp_done_edge);
    @(negedge clk);
    check_output("done_one_cycle", done, 1'b0);
    check_output("busy_after_done", busy, 1'b0);
    check_output("done_count", done_count, 1);
  endtask

  // A full sequence: start sampled at edge 0, then host and monitor in
  // parallel; optionally extra start pulses sampled at edges 5 and 50.
  task automatic run_load(input bit stall, input bit pulse_start, input int exp_done_edge);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    fork
      apply_stimulus(stall, TOTAL_WORDS);
      run_monitor(stall, exp_done_edge);
      begin
        if (pulse_start) begin
          repeat (4) @(negedge clk);
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
          repeat (44) @(negedge clk);
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
    join
    check_output("host_timeout", host_timeout, 1'b0);
  endtask

  // Directed sequence.
  initial begin
    assertions      = 0;
    failures        = 0;
    host_timeout    = 1'b0;
    reset           = 1'b0;
    start           = 1'b0;
    host_if.s_valid = 1'b0;
    host_if.s_data  = '0;

    $display("[TB] reset and idle");
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_output("idle_busy", busy, 1'b0);
      check_output("idle_s_ready", host_if.s_ready, 1'b0);
      check_output("idle_outputs", {cfg_lane, cfg_bn, weight_en, weight_mode, done} == '0, 1'b1);
    end

    $display("[TB] full load, no stalls");
    run_load(1'b0, 1'b0, 117);

    $display("[TB] full load, one stall per word");
    run_load(1'b1, 1'b0, 216);
    check_output("lane_hold", cfg_lane[8], 81);
    check_output("bn_hold", cfg_bn[1], 99);

    $display("[TB] start pulses during a load");
    run_load(1'b0, 1'b1, 117);
    repeat (5) @(negedge clk);
    check_output("no_restart", busy, 1'b0);

    $display("[TB] reset during BN collect of channel 4");
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    apply_stimulus(1'b0, 90);
    check_output("mid_bn_ready", host_if.s_ready, 1'b1);
    check_output("mid_bn_scale", cfg_bn[0], 90);
    reset = 1'b0;
    #1;
    check_output("rst_busy", busy, 1'b0);
    check_output("rst_s_ready", host_if.s_ready, 1'b0);
    check_output("rst_outputs", {cfg_lane, cfg_bn, weight_en, weight_mode, done} == '0, 1'b1);
    @(negedge clk);
    check_output("rst_held_en", weight_en, 1'b0);
    reset = 1'b1;
    run_load(1'b0, 1'b0, 117);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/stage0_cfg_loader.md
# stage0_cfg_loader

Configuration writer for the stage0 depthwise-conv/BN/ReLU array. It accepts a flat word stream from the host over a valid/ready handshake. It packs the stream into nine parallel weight lanes and BN scale/bias pairs, then drives stage0's weight_en, weight_mode, in[8:0] and BN_config_in[1:0] load inputs. The block sits between the host config port and stage0, and owns the load sequence: 81 depthwise taps, then 9 BN pairs shifted into the chain.

## Interface
- int_bits, 13, word width; matches stage0
- CH, 9, channels / lanes
- TAPS, 9, depthwise taps per channel
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low; low forces reset state immediately
- start  in  1  begin a load sequence; sampled only in IDLE
- s_data  in  int_bits  host config word
- s_valid  in  1  s_data valid
- s_ready  out  1  block accepts a word; a transfer occurs on s_valid & s_ready
- cfg_lane[CH-1:0]  out  int_bits each  weight lanes to stage0 in[8:0]
- cfg_bn[1:0]  out  int_bits each  [0]=scale, [1]=bias, to stage0 BN_config_in
- weight_en  out  1  one-cycle load strobe to stage0
- weight_mode  out  1  0=tap load, 1=BN shift
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at end of sequence

## Operation
- Stream order: tap t = 0..8, each as lane words 0..8 (81 words); then channel pairs scale,bias for 9 pairs (18 words); 99 words total.
- Reset values: state IDLE; all cfg_lane, cfg_bn, weight_en, weight_mode, done are 0; all counters are 0.
- s_ready is combinational from state: 1 only in W_COLLECT and BN_COLLECT.
- IDLE: start=1 moves to W_COLLECT and clears lane_cnt, tap_cnt and ch_cnt.
- W_COLLECT: each transfer writes s_data to cfg_lane[lane_cnt] and increments lane_cnt. On the transfer with lane_cnt==8, go to W_PUSH.
- W_PUSH: weight_en=1, weight_mode=0 for exactly one cycle. lane_cnt←0, tap_cnt+1. If tap_cnt was 8, go to BN_COLLECT; else go to W_COLLECT.
- BN_COLLECT: the first transfer writes cfg_bn[0] and the second writes cfg_bn[1], then go to BN_PUSH.
- BN_PUSH: weight_en=1, weight_mode=1 for one cycle, ch_cnt+1. After the ninth push go to DONE; else go to BN_COLLECT. The first pair pushed ends in channel 8 of the chain.
- DONE: done=1 for one cycle, then IDLE.
- weight_en and weight_mode are registered outputs, valid in the push state's cycle.
- cfg_lane and cfg_bn hold their last values after the sequence; they change only on an accepted transfer.
- Counters are 4-bit. No arithmetic on data; words pass through unmodified at full int_bits.
- Boundary rules:
  - start while busy is ignored.
  - s_valid=0 stalls the collect states indefinitely, with no timeout.
  - s_valid is ignored outside the collect states.
  - reset low mid-sequence returns to IDLE with outputs zeroed, and no partial strobe is issued.

## Timing
- Call edge 0 the edge sampling start in IDLE. With s_valid held 1, the first word is accepted at edge 1.
- First weight_en (mode 0) is high in the cycle after edge 9.
- Tap pushes repeat every 10 cycles; the last tap push follows edge 89.
- BN pushes follow edges 92, 95, …, 116.
- done is high in the cycle after edge 117; busy falls after edge 118.
- Minimum sequence length: 118 cycles after edge 0, plus one extra cycle per s_valid=0 cycle in the collect states.
- weight_en is never high on two consecutive cycles.
- s_ready=0 during push cycles, so the host back-pressures for one cycle per group.

## Structure
- Package stage0_cfg_pkg holds:
  - the state enum {IDLE, W_COLLECT, W_PUSH, BN_COLLECT, BN_PUSH, DONE};
  - constants CH=9, TAPS=9, BN_WORDS=2, and TOTAL_WORDS=99.
- Single module; the FSM, three counters and output registers are inline, and no sub-module is warranted.
- Top level instantiates stage0_cfg_loader next to stage0 and wires cfg_lane→in, cfg_bn→BN_config_in.

## Test plan
- Reset then idle: reset low for 3 cycles, release, no start → all outputs 0, s_ready=0, busy=0 for 20 cycles.
- Full load, no stalls: start, words 1..99 with s_valid=1 constantly.
  - Pushes: nine weight_en mode-0 pulses with cfg_lane={9t+9..9t+1} at tap t.
  - Then nine mode-1 pulses with cfg_bn pairs (82,83)…(98,99).
  - done after edge 117.
- Stalls: same stream with s_valid toggling 1/0 → identical push contents; done after edge 216.
- Ignored start: pulse start at edges 5 and 50 during a load → a single sequence, and exactly 18 weight_en pulses.
- Reset mid-load: reset low during BN_COLLECT of ch_cnt=4 → immediate IDLE with outputs 0. A new start with 99 words completes normally.
- Stage0 integration: load known taps/BN and feed a 3×3 frame → stage0 out matches the golden model for relu_sel 0 and 1.
